// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_program_loader
// Brief   : Encodes mnemonic-level instruction beats into 32-bit words and
//           writes them sequentially into instruction memory.
// Rev     : 1.0
// ============================================================================
module imem_program_loader #(
    parameter int         ADDR_W    = 8,
    parameter int         DEPTH     = 256,
    parameter int         BASE_ADDR = 0,
    parameter logic [5:0] FUNCT_ADD = 6'b100010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              load_done,
    output logic              err_full,
    output logic              err_illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_FULL = 2'd3;

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_addi = 4'd1;
    localparam logic [3:0] c_op_subi = 4'd2;
    localparam logic [3:0] c_op_lw   = 4'd3;
    localparam logic [3:0] c_op_sw   = 4'd4;
    localparam logic [3:0] c_op_beq  = 4'd5;
    localparam logic [3:0] c_op_bne  = 4'd6;
    localparam logic [3:0] c_op_j    = 4'd7;

    localparam logic [5:0] c_opc_rtype = 6'b100010;
    localparam logic [5:0] c_opc_addi  = 6'b001000;
    localparam logic [5:0] c_opc_subi  = 6'b011000;
    localparam logic [5:0] c_opc_lw    = 6'b000011;
    localparam logic [5:0] c_opc_sw    = 6'b001011;
    localparam logic [5:0] c_opc_beq   = 6'b110100;
    localparam logic [5:0] c_opc_bne   = 6'b110101;
    localparam logic [5:0] c_opc_j     = 6'b000010;

    localparam int                c_last_slot_int = DEPTH - 1;
    localparam logic [ADDR_W:0]   c_last_slot     = c_last_slot_int[ADDR_W:0];
    localparam logic [ADDR_W-1:0] c_base          = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] c_ptr_one       = 1;
    localparam logic [ADDR_W:0]   c_cnt_one       = 1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [31:0]       w_wdata;
    logic              w_legal;
    logic              w_accept;
    logic              w_fills_last;

    // Instruction assembly; illegal opcodes clear w_legal and write nothing.
    always_comb begin
        w_legal = 1'b1;
        w_wdata = 32'd0;
        case (in_op)
            c_op_add:  w_wdata = {c_opc_rtype, in_rs, in_rt, in_rd, 5'd0, FUNCT_ADD};
            c_op_addi: w_wdata = {c_opc_addi, in_rs, in_rt, in_imm};
            c_op_subi: w_wdata = {c_opc_subi, in_rs, in_rt, in_imm};
            c_op_lw:   w_wdata = {c_opc_lw,   in_rs, in_rt, in_imm};
            c_op_sw:   w_wdata = {c_opc_sw,   in_rs, in_rt, in_imm};
            c_op_beq:  w_wdata = {c_opc_beq,  in_rs, in_rt, in_imm};
            c_op_bne:  w_wdata = {c_opc_bne,  in_rs, in_rt, in_imm};
            c_op_j:    w_wdata = {c_opc_j, in_target};
            default:   w_legal = 1'b0;
        endcase
    end

    assign w_accept     = in_valid && in_ready;
    assign w_fills_last = w_legal && (word_count == c_last_slot);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_LOAD;
        end else if (w_accept) begin
            if (in_last) begin
                w_state_nxt = S_DONE;
            end else if (w_fills_last) begin
                w_state_nxt = S_FULL;
            end
        end
    end

    always_comb begin
        in_ready = (r_state == S_LOAD) && !start;
    end

    // Write port, counters and sticky flags all update on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= 32'd0;
            word_count  <= '0;
            load_done   <= 1'b0;
            err_full    <= 1'b0;
            err_illegal <= 1'b0;
            r_ptr       <= c_base;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                r_ptr       <= c_base;
                word_count  <= '0;
                load_done   <= 1'b0;
                err_full    <= 1'b0;
                err_illegal <= 1'b0;
            end else if (w_accept) begin
                if (w_legal) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= r_ptr;
                    imem_wdata <= w_wdata;
                    r_ptr      <= r_ptr + c_ptr_one;
                    word_count <= word_count + c_cnt_one;
                end else begin
                    err_illegal <= 1'b1;
                end
                if (in_last) begin
                    load_done <= 1'b1;
                end else if (w_fills_last) begin
                    err_full <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_program_loader
// Brief   : Self-checking bench: full-size and DEPTH=4 loaders on shared stimulus.
// Rev     : 1.0
// ============================================================================
module tb_imem_program_loader;

    localparam int SMALL_DEPTH = 4;
    localparam int BIG_DEPTH   = 256;
    localparam logic [5:0] OPC [0:7] = '{6'b100010, 6'b001000, 6'b011000, 6'b000011,
                                         6'b001011, 6'b110100, 6'b110101, 6'b000010};

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        rdy_a, we_a, done_a, full_a, ill_a;
    logic [7:0]  addr_a;
    logic [31:0] wd_a;
    logic [8:0]  cnt_a;
    logic        rdy_b, we_b, done_b, full_b, ill_b;
    logic [7:0]  addr_b;
    logic [31:0] wd_b;
    logic [8:0]  cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_program_loader u_big (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(we_a), .imem_addr(addr_a),
        .imem_wdata(wd_a), .word_count(cnt_a), .load_done(done_a), .err_full(full_a),
        .err_illegal(ill_a)
    );

    imem_program_loader #(.DEPTH(SMALL_DEPTH)) u_small (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(we_b), .imem_addr(addr_b),
        .imem_wdata(wd_b), .word_count(cnt_b), .load_done(done_b), .err_full(full_b),
        .err_illegal(ill_b)
    );

    // Reference: "loading" means beats are welcome; count is slots used so far.
    typedef struct {
        bit          loading;
        bit          we;
        int unsigned addr;
        logic [31:0] wdata;
        int unsigned count;
        bit          done;
        bit          full;
        bit          ill;
    } model_t;

    model_t ma, mb;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        last;
        logic [31:0] exp_w;
        logic [7:0]  exp_a;
    } vec_t;

    vec_t vt [0:4];

    function automatic model_t model_zero();
        model_t z;
        z.loading = 0; z.we = 0; z.addr = 0; z.wdata = 32'd0;
        z.count = 0; z.done = 0; z.full = 0; z.ill = 0;
        return z;
    endfunction

    function automatic logic [31:0] encode(logic [3:0] op, logic [4:0] rs, logic [4:0] rt,
                                           logic [4:0] rd, logic [15:0] imm, logic [25:0] tgt);
        if (op == 4'd0) return {OPC[0], rs, rt, rd, 5'd0, 6'b100010};
        if (op == 4'd7) return {OPC[7], tgt};
        return {OPC[op[2:0]], rs, rt, imm};
    endfunction

    function automatic model_t model_next(model_t m, int depth);
        model_t n = m;
        n.we = 0;
        if (rst) return model_zero();
        if (start) begin
            n.loading = 1; n.count = 0; n.done = 0; n.full = 0; n.ill = 0;
        end else if (m.loading && in_valid) begin
            if (in_op < 4'd8) begin
                n.we    = 1;
                n.addr  = m.count % 256;
                n.wdata = encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
                n.count = m.count + 1;
            end else begin
                n.ill = 1;
            end
            if (in_last) begin
                n.done = 1; n.loading = 0;
            end else if (n.count == depth) begin
                n.full = 1; n.loading = 0;
            end
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("we_a", we_a, ma.we);       chk("we_b", we_b, mb.we);
        chk("addr_a", addr_a, ma.addr); chk("addr_b", addr_b, mb.addr);
        chk("wdata_a", wd_a, ma.wdata); chk("wdata_b", wd_b, mb.wdata);
        chk("count_a", cnt_a, ma.count); chk("count_b", cnt_b, mb.count);
        chk("done_a", done_a, ma.done); chk("done_b", done_b, mb.done);
        chk("full_a", full_a, ma.full); chk("full_b", full_b, mb.full);
        chk("ill_a", ill_a, ma.ill);    chk("ill_b", ill_b, mb.ill);
    endtask

    // Inputs are set at the negedge before calling; outputs checked at the next negedge.
    task automatic cycle();
        #1;
        chk("ready_a", rdy_a, ma.loading && !start);
        chk("ready_b", rdy_b, mb.loading && !start);
        @(posedge clk);
        ma = model_next(ma, BIG_DEPTH);
        mb = model_next(mb, SMALL_DEPTH);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(logic [3:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                         logic [15:0] imm, logic [25:0] tgt, logic last);
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt; in_last = last;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0;
        cycle();
    endtask

    task automatic pulse_start();
        in_valid = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    int wr_b;

    initial begin
        vt[0] = '{4'd1, 5'd0, 5'd5, 5'd0, 16'd7,      26'd0,     1'b0, 32'h20050007, 8'd0};
        vt[1] = '{4'd3, 5'd2, 5'd4, 5'd0, 16'd8,      26'd0,     1'b0, 32'h0C440008, 8'd1};
        vt[2] = '{4'd4, 5'd2, 5'd4, 5'd0, 16'd4,      26'd0,     1'b0, 32'h2C440004, 8'd2};
        vt[3] = '{4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF,   26'd0,     1'b0, 32'hD022FFFF, 8'd3};
        vt[4] = '{4'd7, 5'd0, 5'd0, 5'd0, 16'd0,      26'h40,    1'b1, 32'h08000040, 8'd4};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'd0; in_target = 26'd0;
        ma = model_zero(); mb = model_zero();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        cycle();
        rst = 1'b0;
        idle();

        // Single add beat, written one cycle after acceptance.
        pulse_start();
        drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
        cycle();
        chk("add_we", we_a, 1'b1);
        chk("add_addr", addr_a, 32'h0);
        chk("add_wdata", wd_a, 32'h88221822);
        chk("add_count", cnt_a, 32'd1);
        idle();
        chk("idle_we", we_a, 1'b0);

        // Back-to-back program ending in a jump.
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            drive(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].imm, vt[i].tgt, vt[i].last);
            cycle();
            chk("tbl_we", we_a, 1'b1);
            chk("tbl_addr", addr_a, vt[i].exp_a);
            chk("tbl_wdata", wd_a, vt[i].exp_w);
            chk("tbl_done", done_a, vt[i].last);
        end
        drive(4'd1, 5'd1, 5'd1, 5'd0, 16'd1, 26'd0, 1'b0);
        cycle();
        chk("after_done_ready", rdy_a, 1'b0);
        chk("after_done_we", we_a, 1'b0);

        // DEPTH=4 instance fills up on the fourth of five non-last beats.
        pulse_start();
        wr_b = 0;
        for (int i = 0; i < 5; i++) begin
            drive(4'd1, 5'd0, 5'd1, 5'd0, 16'(i), 26'd0, 1'b0);
            cycle();
            if (we_b) wr_b++;
        end
        idle();
        chk("full_writes", wr_b, 32'd4);
        chk("full_flag", full_b, 1'b1);
        chk("full_ready", rdy_b, 1'b0);
        chk("full_done", done_b, 1'b0);
        chk("full_count", cnt_b, 32'd4);
        chk("full_big_count", cnt_a, 32'd5);

        // Illegal opcode between two legal beats.
        pulse_start();
        drive(4'd1, 5'd0, 5'd1, 5'd0, 16'd1, 26'd0, 1'b0);
        cycle();
        chk("ill_w0_addr", addr_a, 32'd0);
        drive(4'd9, 5'd3, 5'd3, 5'd3, 16'd3, 26'd3, 1'b0);
        cycle();
        chk("ill_no_we", we_a, 1'b0);
        drive(4'd1, 5'd0, 5'd2, 5'd0, 16'd2, 26'd0, 1'b0);
        cycle();
        chk("ill_w1_addr", addr_a, 32'd1);
        idle();
        chk("ill_flag", ill_a, 1'b1);
        chk("ill_count", cnt_a, 32'd2);

        // start while a beat is offered mid-load.
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            drive((i == 2) ? 4'd12 : 4'd2, 5'd1, 5'd2, 5'd0, 16'(i), 26'd0, 1'b0);
            cycle();
        end
        chk("pre_start_full_b", full_b, 1'b1);
        drive(4'd6, 5'd7, 5'd8, 5'd0, 16'h1234, 26'd0, 1'b0);
        start = 1'b1;
        #1 chk("start_ready", rdy_a, 1'b0);
        cycle();
        start = 1'b0;
        chk("start_no_we", we_a, 1'b0);
        chk("start_ill_clr", ill_a, 1'b0);
        chk("start_full_clr", full_b, 1'b0);
        cycle();
        chk("restart_addr", addr_a, 32'd0);
        chk("restart_wdata", wd_a, 32'hD4E81234);
        chk("restart_count", cnt_a, 32'd1);

        // Reset on the edge that would register an accepted beat.
        drive(4'd1, 5'd1, 5'd1, 5'd0, 16'd9, 26'd0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_we", we_a, 1'b0);
        chk("rst_count", cnt_a, 32'd0);
        chk("rst_addr", addr_a, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_ready", rdy_a, 1'b0);
        end

        // Randomized traffic against the reference model.
        pulse_start();
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 249) == 0);
            start     = ($urandom_range(0, 59) == 0) ||
                        ((!ma.loading || !mb.loading) && $urandom_range(0, 5) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                                                     : 4'($urandom_range(0, 7));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_imm    = 16'($urandom);
            in_target = 26'($urandom);
            in_last   = ($urandom_range(0, 29) == 0);
            cycle();
        end
        rst = 1'b0; start = 1'b0;
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Instruction encoder and loader: the writer side of the control decoder's opcode map.
- Accepts mnemonic-level instruction descriptions over a valid/ready stream.
- Assembles each into a 32-bit word using the team's custom opcode map, then writes it sequentially into instruction memory through a registered write port.
- Sits between the host/boot interface and imem; used to load programs before or between CPU runs.

Parameters:
- ADDR_W, 8, width of imem word address.
- DEPTH, 256, number of word slots available to the loader (1..2^ADDR_W).
- BASE_ADDR, 0, first word address written after start.
- FUNCT_ADD, 6'b100010, funct field emitted for add; funct[3:0] = 4'd2 is the ALU add code.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: clear counters and enter LOAD
- in_valid  in  1  instruction beat valid
- in_ready  out  1  loader can accept a beat
- in_op  in  4  0 add, 1 addi, 2 subi, 3 lw, 4 sw, 5 beq, 6 bne, 7 j, 8..15 illegal
- in_rs  in  5  source register
- in_rt  in  5  second source / I-type destination
- in_rd  in  5  R-type destination
- in_imm  in  16  immediate / offset
- in_target  in  26  jump target
- in_last  in  1  final instruction of program
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- word_count  out  ADDR_W+1  words written since start
- load_done  out  1  sticky, program complete
- err_full  out  1  sticky, ran out of slots before last
- err_illegal  out  1  sticky, illegal in_op seen

Behaviour:
- Reset: state IDLE; all outputs 0; address pointer = BASE_ADDR.
- States:
  - IDLE: start -> LOAD.
  - LOAD: normal loading.
  - DONE: start -> LOAD.
  - FULL: start -> LOAD.
- start in any state: pointer = BASE_ADDR, word_count = 0, all sticky flags cleared, state LOAD. A beat is never accepted in the start cycle.
- in_ready = (state == LOAD) && !start; combinational.
- Beat accepted on the cycle where in_valid && in_ready.
- Latency: beat accepted in cycle N -> imem_we = 1 for exactly cycle N+1, with imem_addr and imem_wdata registered. Pointer and word_count increment on the same edge that registers the write.
- Full throughput: back-to-back beats give one write per cycle.
- Encoding, by opcode:
  - add: {6'b100010, rs, rt, rd, 5'b0, FUNCT_ADD}
  - addi 001000, subi 011000, lw 000011, sw 001011, beq 110100, bne 110101: {opcode, rs, rt, imm}
  - j: {6'b000010, target}
- Unused input fields are ignored.
- Illegal in_op (8..15): beat is accepted but not written (imem_we stays 0); err_illegal set; counters unchanged. If in_last is set on an illegal beat, the loader still goes to DONE.
- Last beat: accepting a beat with in_last = 1 moves state to DONE on the same edge. load_done rises in cycle N+1, together with the final write.
- Full: if an accepted non-last beat fills slot DEPTH-1, state goes to FULL and err_full rises in cycle N+1; in_ready drops from N+1.
- Last beat exactly in slot DEPTH-1: DONE, err_full = 0.
- Reset mid-load: abandons any pending write. imem_we is 0 in the cycle after reset, even if a beat was accepted the cycle before.
- In DONE/FULL/IDLE: in_valid is ignored, no writes occur, and outputs hold.

Test Plan:
- rst, start, then beat add rs=1 rt=2 rd=3 last=0 -> next cycle imem_we = 1, addr 0x00, wdata 0x88221822, word_count = 1.
- Back-to-back beats, one per cycle, each written one cycle after acceptance:
  - addi rs=0 rt=5 imm=7 -> 0x20050007
  - lw rs=2 rt=4 imm=8 -> 0x0C440008
  - sw rs=2 rt=4 imm=4 -> 0x2C440004
  - beq rs=1 rt=2 imm=0xFFFF -> 0xD022FFFF
  - j target=0x40 with last=1 -> 0x08000040
  - Expect addresses 0..4 consecutive; load_done rises with the j write; in_ready = 0 afterwards.
- DEPTH = 4, five non-last beats -> four writes to addr 0..3, then err_full = 1 and in_ready = 0. The fifth beat is never accepted; load_done = 0.
- in_op = 9 between two addi beats -> only two writes at addr 0 and 1; err_illegal = 1; word_count = 2.
- start asserted while in_valid is high in LOAD after 3 writes -> that beat is not accepted; next accepted beat writes addr BASE_ADDR; word_count restarts at 1; flags cleared.
- rst asserted the cycle after a beat is accepted -> no imem_we; all outputs 0; in_ready = 0 until start.
